// File: rtl/axis_pretrigger_packetizer.sv
// AXI4-Stream capture gate: passes a pre-trigger fill, waits for a trigger rising edge,
// then passes a fixed number of post-trigger beats ending in tlast.
module axis_pretrigger_packetizer #(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH       = 32,
  parameter string CONTINUOUS       = "FALSE",
  parameter string NON_BLOCKING     = "FALSE"
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_pre,
  input  logic [CNTR_WIDTH-1:0]       cfg_post,
  input  logic                        arm,
  input  logic                        trigger,
  output logic [CNTR_WIDTH-1:0]       trigger_pos,
  output logic                        enabled,
  output logic                        triggered,
  output logic                        complete,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  localparam bit CONT = (CONTINUOUS == "TRUE");
  localparam bit NB   = (NON_BLOCKING == "TRUE");
  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

  state_t state, state_next, restart_state;
  logic [CNTR_WIDTH-1:0] cfg_pre_q, cfg_post_q, wr_ptr, pre_cnt, post_cnt;
  logic trigger_d, xfer, trig_edge, armed_edge, post_last, finish, start;

  always_comb begin
    enabled       = (state == FILL) || (state == ARMED) || (state == POST);
    triggered     = (state == POST);
    m_axis_tdata  = s_axis_tdata;
    m_axis_tvalid = enabled & s_axis_tvalid;
    s_axis_tready = NB ? (~enabled | m_axis_tready) : (enabled & m_axis_tready);
    xfer          = m_axis_tvalid & m_axis_tready;
    trig_edge     = trigger & ~trigger_d;
    armed_edge    = (state == ARMED) & trig_edge;
    // The edge-cycle beat is post beat #1, so a one-beat packet ends in ARMED itself.
    post_last     = ((state == POST) && (post_cnt == cfg_post_q - ONE)) ||
                    (armed_edge && (cfg_post_q == ONE));
    m_axis_tlast  = post_last;
    finish        = (post_last & xfer) | (armed_edge & (cfg_post_q == '0));
    start         = arm & ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    restart_state = CONT ? ((cfg_pre_q == '0) ? ARMED : FILL) : DONE;
    state_next    = state;
    case (state)
      IDLE, DONE: if (arm) state_next = (cfg_pre == '0) ? ARMED : FILL;
      FILL:       if (xfer && (pre_cnt == cfg_pre_q - ONE)) state_next = ARMED;
      ARMED: begin
        if (finish)          state_next = restart_state;
        else if (armed_edge) state_next = POST;
      end
      POST:       if (finish) state_next = restart_state;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      cfg_pre_q   <= '0;
      cfg_post_q  <= '0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      trigger_pos <= '0;
      trigger_d   <= 1'b0;
      complete    <= 1'b0;
    end else begin
      state     <= state_next;
      trigger_d <= trigger;
      if (start) begin
        cfg_pre_q  <= cfg_pre;
        cfg_post_q <= cfg_post;
        wr_ptr     <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        complete   <= 1'b0;
      end else begin
        if (xfer) wr_ptr <= wr_ptr + ONE;
        if ((state == FILL) && xfer) pre_cnt <= pre_cnt + ONE;
        if (armed_edge) begin
          trigger_pos <= wr_ptr;
          post_cnt    <= xfer ? ONE : '0;
        end
        if ((state == POST) && xfer) post_cnt <= post_cnt + ONE;
        if (finish) begin
          pre_cnt  <= '0;
          post_cnt <= '0;
          complete <= 1'b1;
        end else if (CONT) begin
          complete <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pretrigger_packetizer.sv
// Bench for axis_pretrigger_packetizer: a one-shot 32-bit instance and a continuous,
// non-blocking 4-bit-counter instance, both checked every cycle against a beat-level model.
module tb_axis_pretrigger_packetizer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        trigger = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        arm_a = 1'b0, arm_b = 1'b0;
  logic [31:0] cfg_pre_a = '0, cfg_post_a = '0;
  logic [3:0]  cfg_pre_b = '0, cfg_post_b = '0;

  logic [31:0] tpos_a, tdata_a, tdata_b;
  logic [3:0]  tpos_b;
  logic en_a, trg_a, cmp_a, str_a, tv_a, tl_a;
  logic en_b, trg_b, cmp_b, str_b, tv_b, tl_b;

  always #5 clk = ~clk;

  axis_pretrigger_packetizer #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32),
    .CONTINUOUS("FALSE"), .NON_BLOCKING("FALSE")) dut_a (
    .aclk(clk), .aresetn(aresetn), .cfg_pre(cfg_pre_a), .cfg_post(cfg_post_a),
    .arm(arm_a), .trigger(trigger), .trigger_pos(tpos_a), .enabled(en_a),
    .triggered(trg_a), .complete(cmp_a), .s_axis_tready(str_a),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tv_a), .m_axis_tlast(tl_a));

  axis_pretrigger_packetizer #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(4),
    .CONTINUOUS("TRUE"), .NON_BLOCKING("TRUE")) dut_b (
    .aclk(clk), .aresetn(aresetn), .cfg_pre(cfg_pre_b), .cfg_post(cfg_post_b),
    .arm(arm_b), .trigger(trigger), .trigger_pos(tpos_b), .enabled(en_b),
    .triggered(trg_b), .complete(cmp_b), .s_axis_tready(str_b),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tv_b), .m_axis_tlast(tl_b));

  int checks = 0, failures = 0;
  int pbeats_a, tlast_a, tlast_b, pulses_b, en_low_b;

  // Beat-level reference: n = beats in current packet, ptr = beats since arm,
  // trig_at = packet beat index of the accepted trigger (-1 while waiting).
  bit          act[2], cmpm[2];
  int          n[2], ptr[2], pre[2], post[2], trig_at[2];
  logic [31:0] tposm[2];
  bit          trig_prev;
  bit          cont[2] = '{1'b0, 1'b1};
  bit          nb[2]   = '{1'b0, 1'b1};
  logic [31:0] mask[2] = '{32'hFFFF_FFFF, 32'h0000_000F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int teff(input int i);
    if (!act[i]) return -1;
    if (trig_at[i] >= 0) return trig_at[i];
    if (n[i] >= pre[i] && trigger && !trig_prev) return n[i];
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; cmpm[i] = 0; n[i] = 0; ptr[i] = 0;
      pre[i] = 0; post[i] = 0; trig_at[i] = -1; tposm[i] = '0;
    end
    trig_prev = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit armi = (i == 1) ? arm_b : arm_a;
      bit was  = act[i];
      bit x    = act[i] && s_tvalid && m_tready;
      int te   = teff(i);
      bit fin  = (te >= 0) && (post[i] == 0 || (x && n[i] == te + post[i] - 1));
      if (trig_at[i] < 0 && te >= 0) begin
        tposm[i]   = 32'(ptr[i]) & mask[i];
        trig_at[i] = te;
      end
      if (x) begin n[i]++; ptr[i]++; end
      if (fin) begin
        trig_at[i] = -1; n[i] = 0; cmpm[i] = 1;
        if (!cont[i]) act[i] = 0;
      end else if (cont[i]) cmpm[i] = 0;
      if (!was && armi) begin
        pre[i]  = (i == 1) ? int'(cfg_pre_b)  : int'(cfg_pre_a);
        post[i] = (i == 1) ? int'(cfg_post_b) : int'(cfg_post_a);
        n[i] = 0; ptr[i] = 0; trig_at[i] = -1; cmpm[i] = 0; act[i] = 1;
      end
    end
    trig_prev = trigger;
  endtask

  task automatic chk_inst(input int i, input logic en, input logic trg, input logic tv,
                          input logic tl, input logic str, input logic [31:0] td,
                          input logic cm, input logic [31:0] tp);
    string p = (i == 1) ? "b" : "a";
    int te = teff(i);
    bit exp_last = (te >= 0) && (post[i] > 0) && (n[i] == te + post[i] - 1);
    bit exp_rdy  = nb[i] ? (!act[i] || m_tready) : (act[i] && m_tready);
    chk({p, ".enabled"},   32'(en),  32'(act[i]));
    chk({p, ".triggered"}, 32'(trg), 32'(act[i] && trig_at[i] >= 0));
    chk({p, ".tvalid"},    32'(tv),  32'(act[i] && s_tvalid));
    chk({p, ".tlast"},     32'(tl),  32'(exp_last));
    chk({p, ".tready"},    32'(str), 32'(exp_rdy));
    chk({p, ".tdata"},     td,       s_tdata);
    chk({p, ".complete"},  32'(cm),  32'(cmpm[i]));
    chk({p, ".trig_pos"},  tp,       tposm[i]);
  endtask

  task automatic check_all();
    chk_inst(0, en_a, trg_a, tv_a, tl_a, str_a, tdata_a, cmp_a, tpos_a);
    chk_inst(1, en_b, trg_b, tv_b, tl_b, str_b, tdata_b, cmp_b, 32'(tpos_b));
  endtask

  task automatic clr();
    pbeats_a = 0; tlast_a = 0; tlast_b = 0; pulses_b = 0; en_low_b = 0;
  endtask

  task automatic cyc(input bit tv, input bit tr, input bit tg);
    s_tvalid = tv; m_tready = tr; trigger = tg; s_tdata = $urandom;
    #1;
    if (tv_a && m_tready && teff(0) >= 0) pbeats_a++;
    if (tl_a && tv_a && m_tready) tlast_a++;
    if (tl_b && tv_b && m_tready) tlast_b++;
    if (cmp_b) pulses_b++;
    if (!en_b) en_low_b++;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
    arm_a = 1'b0; arm_b = 1'b0;
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset.trig_pos", tpos_a, 32'd0);
    @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    model_reset();
    clr();
    @(negedge clk);
    check_all();
    aresetn = 1'b1;

    // Basic capture: fill 4, edge at beat 10, 3 post beats.
    cfg_pre_a = 4; cfg_post_a = 3; arm_a = 1'b1;
    cyc(1, 1, 0);
    clr();
    for (int k = 0; k < 50 && n[0] < 10; k++) cyc(1, 1, 0);
    cyc(1, 1, 1);
    for (int k = 0; k < 20 && act[0]; k++) cyc(1, 1, 1);
    cyc(1, 1, 1);
    chk("t1.trig_pos", tpos_a, 32'd10);
    chk("t1.complete", 32'(cmp_a), 32'd1);
    chk("t1.tready_after", 32'(str_a), 32'd0);
    chk("t1.post_beats", 32'(pbeats_a), 32'd3);
    chk("t1.tlast_count", 32'(tlast_a), 32'd1);

    // Trigger held high through fill; fresh edge at beat 7. Re-arm from DONE.
    cfg_pre_a = 3; cfg_post_a = 2; arm_a = 1'b1;
    clr();
    cyc(1, 1, 1);
    chk("t2.complete_cleared", 32'(cmp_a), 32'd0);
    for (int k = 0; k < 50 && n[0] < 6; k++) cyc(1, 1, 1);
    chk("t2.still_armed", 32'(trg_a), 32'd0);
    cyc(1, 1, 0);
    cyc(1, 1, 1);
    chk("t2.trig_pos", tpos_a, 32'd7);
    for (int k = 0; k < 20 && act[0]; k++) cyc(1, 1, 1);
    chk("t2.tlast_count", 32'(tlast_a), 32'd1);

    // Random backpressure, random trigger activity.
    cfg_pre_a = 3; cfg_post_a = 5; arm_a = 1'b1;
    cyc(1, 1, 0);
    clr();
    for (int k = 0; k < 600 && act[0]; k++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("t3.closed", 32'(en_a), 32'd0);
    chk("t3.post_beats", 32'(pbeats_a), 32'd5);
    chk("t3.tlast_count", 32'(tlast_a), 32'd1);

    // cfg_pre=0 / cfg_post=0: edge finishes the capture with no tlast.
    cfg_pre_a = 0; cfg_post_a = 0; arm_a = 1'b1;
    cyc(1, 1, 0);
    clr();
    cyc(1, 1, 0);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    chk("e0.trig_pos", tpos_a, 32'd1);
    chk("e0.complete", 32'(cmp_a), 32'd1);
    chk("e0.closed", 32'(en_a), 32'd0);
    chk("e0.no_tlast", 32'(tlast_a), 32'd0);

    // Reset mid-POST, then a clean one-beat capture.
    cfg_pre_a = 2; cfg_post_a = 4; arm_a = 1'b1;
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    chk("t6.in_post", 32'(trg_a), 32'd1);
    do_reset();
    cfg_pre_a = 1; cfg_post_a = 1; arm_a = 1'b1;
    clr();
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    chk("t6.trig_pos", tpos_a, 32'd1);
    chk("t6.tlast_count", 32'(tlast_a), 32'd1);
    chk("t6.complete", 32'(cmp_a), 32'd1);

    // 4-bit pointer wrap: fill 14, trigger at beat 17.
    cfg_pre_b = 14; cfg_post_b = 3; arm_b = 1'b1;
    cyc(1, 1, 0);
    clr();
    for (int k = 0; k < 60 && n[1] < 17; k++) cyc(1, 1, 0);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    chk("t4.trig_pos", 32'(tpos_b), 32'd1);
    chk("t4.tlast_count", 32'(tlast_b), 32'd1);
    chk("t4.complete_pulse", 32'(cmp_b), 32'd1);
    chk("t4.gate_open", 32'(en_b), 32'd1);
    cyc(1, 1, 1);
    chk("t4.pulse_end", 32'(cmp_b), 32'd0);

    do_reset();
    m_tready = 1'b0; s_tvalid = 1'b0;
    #1;
    chk("nb.idle_tready", 32'(str_b), 32'd1);
    chk("blk.idle_tready", 32'(str_a), 32'd0);

    // Continuous: two edges, two packets, gate never closes.
    cfg_pre_b = 2; cfg_post_b = 2; arm_b = 1'b1;
    cyc(1, 1, 0);
    clr();
    for (int k = 0; k < 20; k++) cyc(1, 1, (k % 10) >= 5);
    chk("t5.complete_pulses", 32'(pulses_b), 32'd2);
    chk("t5.tlast_count", 32'(tlast_b), 32'd2);
    chk("t5.gate_closed_cycles", 32'(en_low_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
